// File: rtl/i2s_tx.sv
// I2S frame-master transmitter: serialises stereo sample pairs MSB-first with the
// standard one-bit delay, fed through a one-entry valid/ready holding buffer.
module i2s_tx #(
   parameter int DATALEN = 16,
   parameter int SLOTLEN = 32
) (
   input  logic               bclk,
   input  logic               reset,
   input  logic [DATALEN-1:0] left_in,
   input  logic [DATALEN-1:0] right_in,
   input  logic               valid_in,
   output logic               ready_out,
   output logic               lrclk,
   output logic               sdata,
   output logic               frame_tick,
   output logic               underrun
);

   localparam int CW = $clog2(2*SLOTLEN);
   localparam logic [CW-1:0] LAST = CW'(2*SLOTLEN-1);
   localparam logic [CW-1:0] SLOT = CW'(SLOTLEN);

   generate
      if (SLOTLEN < DATALEN+1) begin : g_bad_slotlen
         $error("i2s_tx: SLOTLEN must be at least DATALEN+1");
      end
   endgenerate

   logic [CW-1:0]      cnt, cnt_nxt, pos;
   logic [DATALEN-1:0] act_l, act_r, act_l_nxt, act_r_nxt, word;
   logic [DATALEN-1:0] pend_l, pend_r;
   logic               pend_full, load, accept, lr_nxt, sd_nxt;

   assign ready_out = !pend_full && !reset;
   assign accept    = valid_in && ready_out;

   // Outputs are registered from the next-cycle counter and active words so that
   // lrclk/sdata line up with the cycle in which cnt holds the matching value.
   always_comb begin
      load      = (cnt == LAST);
      cnt_nxt   = load ? '0 : cnt + CW'(1);
      act_l_nxt = act_l;
      act_r_nxt = act_r;
      if (load) begin
         act_l_nxt = pend_full ? pend_l : '0;
         act_r_nxt = pend_full ? pend_r : '0;
      end
      lr_nxt = (cnt_nxt >= SLOT);
      pos    = lr_nxt ? cnt_nxt - SLOT : cnt_nxt;
      word   = lr_nxt ? act_r_nxt : act_l_nxt;
      sd_nxt = 1'b0;
      for (int i = 0; i < DATALEN; i++)
         if (pos == CW'(DATALEN - i)) sd_nxt = word[i];
   end

   always_ff @(posedge bclk) begin
      if (reset) begin
         cnt        <= '0;
         act_l      <= '0;
         act_r      <= '0;
         pend_l     <= '0;
         pend_r     <= '0;
         pend_full  <= 1'b0;
         lrclk      <= 1'b0;
         sdata      <= 1'b0;
         frame_tick <= 1'b0;
         underrun   <= 1'b0;
      end else begin
         cnt        <= cnt_nxt;
         act_l      <= act_l_nxt;
         act_r      <= act_r_nxt;
         lrclk      <= lr_nxt;
         sdata      <= sd_nxt;
         frame_tick <= load;
         underrun   <= load && !pend_full;
         // accept needs an empty buffer, a draining load needs a full one
         if (accept) begin
            pend_l    <= left_in;
            pend_r    <= right_in;
            pend_full <= 1'b1;
         end else if (load) begin
            pend_full <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_i2s_tx.sv
// Directed bench for i2s_tx: cycle model with a pending-pair queue, per-cycle
// monitor, and frame captures compared against literal sample words.
module tb_i2s_tx;

   logic        bclk = 1'b0;
   logic        reset = 1'b1;
   logic        valid_in = 1'b0;
   logic [15:0] left_in = '0;
   logic [15:0] right_in = '0;
   logic        ready_out, lrclk, sdata, frame_tick, underrun;

   int n_pass = 0;
   int n_total = 0;

   i2s_tx #(.DATALEN(16), .SLOTLEN(32)) dut (
      .bclk       (bclk),
      .reset      (reset),
      .left_in    (left_in),
      .right_in   (right_in),
      .valid_in   (valid_in),
      .ready_out  (ready_out),
      .lrclk      (lrclk),
      .sdata      (sdata),
      .frame_tick (frame_tick),
      .underrun   (underrun)
   );

   always #5 bclk = ~bclk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // reference model: pairs are queued on accept and popped at the frame load
   logic [31:0] q[$];
   logic [15:0] m_l = '0, m_r = '0;
   int          m_cnt = 0;
   bit          m_on = 0, m_tick = 0, m_under = 0;

   always @(posedge bclk) begin : model
      bit ld, acc;
      logic [31:0] pr;
      if (reset) begin
         m_on = 1; m_cnt = 0; m_l = '0; m_r = '0; q.delete(); m_tick = 0; m_under = 0;
      end else if (m_on) begin
         ld      = (m_cnt == 63);
         acc     = valid_in && (q.size() == 0);
         m_tick  = ld;
         m_under = ld && (q.size() == 0);
         if (ld) begin
            if (q.size() > 0) begin
               pr = q.pop_front();
               m_l = pr[31:16];
               m_r = pr[15:0];
            end else begin
               m_l = '0;
               m_r = '0;
            end
         end
         if (acc) q.push_back({left_in, right_in});
         m_cnt = ld ? 0 : m_cnt + 1;
      end
   end

   always begin : mon
      int p;
      logic [15:0] w;
      logic es;
      @(negedge bclk);
      #2;
      if (m_on) begin
         p  = m_cnt % 32;
         w  = (m_cnt >= 32) ? m_r : m_l;
         es = (p >= 1 && p <= 16) ? w[16-p] : 1'b0;
         check("mon_sdata", sdata, es);
         check("mon_lrclk", lrclk, m_cnt >= 32);
         check("mon_ready", ready_out, !reset && q.size() == 0);
         check("mon_tick", frame_tick, m_tick);
         check("mon_under", underrun, m_under);
      end
   end

   task automatic wait_cnt(input int c);
      int n = 0;
      while (m_cnt != c && n < 300) begin
         @(negedge bclk);
         n++;
      end
      if (m_cnt != c) check("wait_cnt", m_cnt, c);
   endtask

   task automatic do_reset();
      @(negedge bclk);
      reset = 1'b1;
      valid_in = 1'b0;
      repeat (2) @(negedge bclk);
      check("rst_lrclk", lrclk, 0);
      check("rst_sdata", sdata, 0);
      check("rst_ready", ready_out, 0);
      check("rst_under", underrun, 0);
      check("rst_tick", frame_tick, 0);
      reset = 1'b0;
      #1;
      check("rst_ready_rel", ready_out, 1);
   endtask

   task automatic offer(input logic [15:0] l, input logic [15:0] r);
      left_in = l;
      right_in = r;
      valid_in = 1'b1;
      @(negedge bclk);
      valid_in = 1'b0;
   endtask

   // call with m_cnt==0; walks one whole frame and returns at the next cnt==0
   task automatic check_frame(input string tag, input logic [15:0] el, input logic [15:0] er,
                              input int eun);
      logic [15:0] l = '0, r = '0;
      int extra = 0, unders = 0, lr_err = 0;
      for (int i = 0; i < 64; i++) begin
         int p;
         p = i % 32;
         if (lrclk !== (i >= 32)) lr_err++;
         if (p >= 1 && p <= 16) begin
            if (i < 32) l = {l[14:0], sdata};
            else r = {r[14:0], sdata};
         end else if (sdata !== 1'b0) extra++;
         if (underrun) unders++;
         @(negedge bclk);
      end
      check({tag, "_left"}, l, el);
      check({tag, "_right"}, r, er);
      check({tag, "_idle_bits"}, extra, 0);
      check({tag, "_lrclk"}, lr_err, 0);
      check({tag, "_underrun"}, unders, eun);
   endtask

   initial begin
      logic [15:0] pl[5];
      logic [15:0] pr[5];
      pl = '{16'h1357, 16'hFFFF, 16'h0001, 16'hC3A5, 16'h8001};
      pr = '{16'h2468, 16'h0000, 16'h8000, 16'h5A3C, 16'h7FFE};

      // idle: first frame silent and not an underrun, later frames flag underrun
      do_reset();
      check_frame("idle_f1", 16'h0, 16'h0, 0);
      check_frame("idle_f2", 16'h0, 16'h0, 1);
      check_frame("idle_f3", 16'h0, 16'h0, 1);

      // single pair offered in frame 1 appears in frame 2
      do_reset();
      wait_cnt(10);
      offer(16'hA5F0, 16'h0F0F);
      wait_cnt(0);
      check_frame("pair_f2", 16'hA5F0, 16'h0F0F, 0);

      // back-to-back stream, one accept per frame
      do_reset();
      fork
         begin
            for (int k = 0; k < 5; k++) begin
               int n;
               n = 0;
               left_in = pl[k];
               right_in = pr[k];
               valid_in = 1'b1;
               while (!ready_out && n < 200) begin
                  @(negedge bclk);
                  n++;
               end
               if (!ready_out) check("stream_ready_wait", ready_out, 1);
               @(negedge bclk);
            end
            valid_in = 1'b0;
         end
         begin
            @(negedge bclk);
            wait_cnt(0);
            for (int j = 0; j < 5; j++)
               check_frame($sformatf("stream_f%0d", j + 2), pl[j], pr[j], 0);
         end
      join

      // sign-bit placement
      do_reset();
      wait_cnt(5);
      offer(16'h8000, 16'h7FFF);
      wait_cnt(0);
      check_frame("sign_f2", 16'h8000, 16'h7FFF, 0);

      // reset mid-frame drops the pending pair
      do_reset();
      wait_cnt(3);
      offer(16'hFFFF, 16'hFFFF);
      wait_cnt(20);
      reset = 1'b1;
      @(negedge bclk);
      check("midrst_lrclk", lrclk, 0);
      check("midrst_sdata", sdata, 0);
      check("midrst_ready", ready_out, 0);
      reset = 1'b0;
      #1;
      check("midrst_ready_rel", ready_out, 1);
      check_frame("midrst_f1", 16'h0, 16'h0, 0);
      check_frame("midrst_f2", 16'h0, 16'h0, 1);

      // accept exactly on the load edge: that frame mutes, next one carries it
      do_reset();
      wait_cnt(63);
      offer(16'h1234, 16'hABCD);
      check("edge_tick", frame_tick, 1);
      check("edge_ready", ready_out, 0);
      check_frame("edge_f2", 16'h0, 16'h0, 1);
      check_frame("edge_f3", 16'h1234, 16'hABCD, 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/i2s_tx.md
# i2s_tx

Parallel-to-serial I2S transmitter clocked on `bclk`, acting as frame master: generates `lrclk` and drives the codec DAC data line from stereo sample pairs. Sits at the output end of the audio path and accepts processed samples (e.g. from the SPRAM echo stage) through a valid/ready handshake with a one-entry holding buffer. Underruns are muted and flagged.

## Interface
- `DATALEN`, 16, sample width in bits, two's complement.
- `SLOTLEN`, 32, `bclk` cycles per channel slot; must satisfy `SLOTLEN >= DATALEN+1`, else elaboration error.
- `bclk`  in  1  bit clock, sole clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `left_in`  in  DATALEN  left sample of offered pair.
- `right_in`  in  DATALEN  right sample of offered pair.
- `valid_in`  in  1  offered pair valid.
- `ready_out`  out  1  holding buffer empty; pair accepted when `valid_in & ready_out` at a rising edge.
- `lrclk`  out  1  word select: 0 = left slot, 1 = right slot.
- `sdata`  out  1  serial data to codec.
- `frame_tick`  out  1  one-cycle pulse at the start of each frame (new pair loaded).
- `underrun`  out  1  one-cycle pulse when a frame starts with the holding buffer empty.

## Operation
- Frame counter `cnt`, width `$clog2(2*SLOTLEN)`, counts 0..2*SLOTLEN-1, wraps to 0.
- Slot position `p = cnt mod SLOTLEN`; `lrclk = (cnt >= SLOTLEN)`.
- Active pair registers `act_l`, `act_r` hold the pair being shifted.
- `sdata` in slot: p=0 → 0 (I2S one-bit delay); p=1..DATALEN → bit `DATALEN-p` of the slot's active word (MSB first); p>DATALEN → 0.
- Holding buffer `pend_l`, `pend_r`, flag `pend_full`; `ready_out = !pend_full` (forced 0 while `reset` high).
- Accept: `valid_in & ready_out` → capture both inputs, `pend_full <= 1`. Pair captured atomically; no partial acceptance.
- Frame load on the edge where `cnt` goes 2*SLOTLEN-1 → 0:
  - `pend_full=1`: `act <= pend`, `pend_full <= 0`.
  - `pend_full=0`: `act <= 0` (mute), `underrun` high for the cycle with `cnt==0`.
- Accept and load cannot collide (accept requires `pend_full=0`, load only transfers when `pend_full=1`). An accept on the load edge with `pend_full=0` lands in the holding buffer for the following frame; that frame still mutes and flags underrun.
- Reset: `cnt=0`, `lrclk=0`, `sdata=0`, `act=0`, `pend=0`, `pend_full=0`, `frame_tick=0`, `underrun=0`. Reset mid-frame aborts the frame and discards the pending pair.
- First frame after reset transmits zeros; it is not reported as an underrun and `frame_tick` is not pulsed for it.

## Timing
- `lrclk` and `sdata` are registered and change only on rising `bclk`; the codec samples on the next rising edge (one full period of setup).
- In the cycle where `cnt==c`, `lrclk` and `sdata` reflect `c` per the rules above. The first cycle after reset release has `cnt==0`.
- Frame period is `2*SLOTLEN` `bclk` cycles (64 at default).
- `frame_tick` is high exactly in cycles with `cnt==0`, excluding the first post-reset frame.
- Latency: a pair accepted at any edge during frame N is transmitted in frame N+1. Left MSB appears at `cnt==1`; right MSB at `cnt==SLOTLEN+1`.
- `ready_out` rises in the cycle after a load (`cnt==0`) and stays high until the next accept. Throughput is one pair per frame.

## Test plan
- Reset, then hold `valid_in=0` for 3 frames → `sdata` constantly 0, `lrclk` toggles every 32 cycles, `underrun` pulses at `cnt==0` of frames 2 and 3, never in frame 1.
- Offer left=16'hA5F0, right=16'h0F0F once during frame 1 → frame 2: `sdata` at cnt 1..16 = 1010010111110000, cnt 33..48 = 0000111100001111, all other cycles 0; no underrun in frame 2.
- Hold `valid_in=1` with a new pair every accept → exactly one accept per frame, `ready_out` low from accept until the next `cnt==0`, zero underruns, each frame carries the next pair in order.
- Offer left=16'h8000, right=16'h7FFF → `sdata` high only at cnt 1 (left) and at cnt 34..48 (right); verifies sign-bit placement and MSB-first order.
- Assert `reset` at `cnt==20` with a pair pending → next cycle `lrclk=0`, `sdata=0`, `ready_out=0`; after release `cnt` restarts at 0, the pending pair is never transmitted, and `ready_out=1`.
- Offer a pair on the exact edge of `cnt` 63 → 0 while the buffer is empty → frame just started is muted with `underrun`=1, and the pair is transmitted in the following frame.
